// File: rtl/scaler_defs_pkg.sv
// Shared scaler definitions: algorithm codes, zoom levels and per-algorithm
// zoom limits, used by the front panel, the scaler core and the display stage.
package scaler_defs;

  localparam logic [1:0] ALG_NN   = 2'd0;
  localparam logic [1:0] ALG_REPL = 2'd1;
  localparam logic [1:0] ALG_DEC  = 2'd2;
  localparam logic [1:0] ALG_AVG  = 2'd3;

  localparam logic [2:0] ZOOM_QUARTER = 3'd0;
  localparam logic [2:0] ZOOM_HALF    = 3'd1;
  localparam logic [2:0] ZOOM_1X      = 3'd2;
  localparam logic [2:0] ZOOM_2X      = 3'd3;
  localparam logic [2:0] ZOOM_4X      = 3'd4;

  localparam logic [2:0] ZOOM_MIN_UPSCALE   = ZOOM_1X;
  localparam logic [2:0] ZOOM_MAX_UPSCALE   = ZOOM_4X;
  localparam logic [2:0] ZOOM_MIN_DOWNSCALE = ZOOM_QUARTER;
  localparam logic [2:0] ZOOM_MAX_DOWNSCALE = ZOOM_1X;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_FIRE = 2'd2
  } ctrl_state_e;

  function automatic logic [2:0] zoom_min(input logic [1:0] alg);
    case (alg)
      ALG_NN, ALG_REPL: return ZOOM_MIN_UPSCALE;
      default:          return ZOOM_MIN_DOWNSCALE;
    endcase
  endfunction

  function automatic logic [2:0] zoom_max(input logic [1:0] alg);
    case (alg)
      ALG_NN, ALG_REPL: return ZOOM_MAX_UPSCALE;
      default:          return ZOOM_MAX_DOWNSCALE;
    endcase
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a whole-word debouncer: the word commits
// only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
module input_debouncer #(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic             settled
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync1, sync2, sample;
  logic [CW-1:0]    count, run;

  // run = length of the current stable streak including this sample, saturating
  always_comb begin
    run = CW'(1);
    if (sync2 == sample) begin
      if (count == CNT_DONE) begin
        run = count;
      end else begin
        run = count + CW'(1);
      end
    end else begin
      run = CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= RESET_VALUE;
      sync2   <= RESET_VALUE;
      sample  <= RESET_VALUE;
      level   <= RESET_VALUE;
      count   <= '0;
      settled <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      sample <= sync2;
      count  <= run;
      if (run == CNT_DONE) begin
        level   <= sync2;
        settled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/algorithm_zoom_selector.sv
// Front-panel input stage: debounced switches/keys decoded into algorithm,
// zoom level, error flags and a one-cycle start handshake to the scaler core.
module algorithm_zoom_selector
  import scaler_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       key_zoom_in_n,
  input  logic       key_zoom_out_n,
  input  logic       busy,
  output logic [1:0] algorithm_select,
  output logic [2:0] zoom_level,
  output logic       start,
  output logic       no_switch_selected_error,
  output logic       multiple_switches_error,
  output logic       invalid_zoom_error
);

  logic [3:0]  sw_level;
  logic        sw_settled;
  logic [1:0]  key_level, key_prev, press;
  logic        key_settled;
  logic        configured;
  logic        sw_zero, sw_one_hot, sw_none_err, sw_multi_err, sw_err;
  logic [1:0]  sw_idx;
  logic        alg_change, key_ok, zin, zout, zin_ok, zout_ok, zoom_reject, cfg_event;
  logic [2:0]  zoom_up, zoom_dn;
  ctrl_state_e state, state_next;

  input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(4'b0000)) u_sw_db (
    .clk(clk), .reset(reset), .raw(sw), .level(sw_level), .settled(sw_settled)
  );

  input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(2'b11)) u_key_db (
    .clk(clk), .reset(reset), .raw({key_zoom_out_n, key_zoom_in_n}),
    .level(key_level), .settled(key_settled)
  );

  assign sw_zero      = (sw_level == 4'b0000);
  assign sw_one_hot   = !sw_zero && ((sw_level & (sw_level - 4'd1)) == 4'b0000);
  assign sw_none_err  = sw_settled && sw_zero;
  assign sw_multi_err = sw_settled && !sw_zero && !sw_one_hot;
  assign sw_err       = sw_none_err || sw_multi_err;

  always_comb begin
    sw_idx = ALG_NN;
    case (sw_level)
      4'b0010: sw_idx = ALG_REPL;
      4'b0100: sw_idx = ALG_DEC;
      4'b1000: sw_idx = ALG_AVG;
      default: sw_idx = ALG_NN;
    endcase
  end

  // The first valid selection after reset counts as a change so the core gets a start.
  assign alg_change  = sw_settled && sw_one_hot && (!configured || (sw_idx != algorithm_select));
  assign press       = key_settled ? (key_prev & ~key_level) : 2'b00;
  assign key_ok      = sw_settled && sw_one_hot && !alg_change && !busy;
  assign zin         = key_ok && (press == 2'b01);
  assign zout        = key_ok && (press == 2'b10);
  assign zoom_up     = zoom_level + 3'd1;
  assign zoom_dn     = zoom_level - 3'd1;
  assign zin_ok      = zin && (zoom_up <= zoom_max(algorithm_select));
  assign zout_ok     = zout && (zoom_level > zoom_min(algorithm_select));
  assign zoom_reject = (zin && !zin_ok) || (zout && !zout_ok);
  assign cfg_event   = alg_change || zin_ok || zout_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    if (cfg_event) begin
      state_next = busy ? ST_PEND : ST_FIRE;
    end else begin
      case (state)
        ST_PEND: begin
          if (sw_err) begin
            state_next = ST_IDLE;
          end else begin
            state_next = busy ? ST_PEND : ST_FIRE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start = 1'b0;
    if (state == ST_FIRE) begin
      start = 1'b1;
    end else begin
      start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      algorithm_select         <= ALG_NN;
      zoom_level               <= ZOOM_1X;
      invalid_zoom_error       <= 1'b0;
      no_switch_selected_error <= 1'b0;
      multiple_switches_error  <= 1'b0;
      configured               <= 1'b0;
      key_prev                 <= 2'b11;
    end else begin
      key_prev                 <= key_level;
      no_switch_selected_error <= sw_none_err;
      multiple_switches_error  <= sw_multi_err;
      if (alg_change) begin
        algorithm_select   <= sw_idx;
        zoom_level         <= ZOOM_1X;
        invalid_zoom_error <= 1'b0;
        configured         <= 1'b1;
      end else if (sw_err) begin
        invalid_zoom_error <= 1'b0;
      end else if (zin_ok) begin
        zoom_level         <= zoom_up;
        invalid_zoom_error <= 1'b0;
      end else if (zout_ok) begin
        zoom_level         <= zoom_dn;
        invalid_zoom_error <= 1'b0;
      end else if (zoom_reject) begin
        invalid_zoom_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_algorithm_zoom_selector.sv
// Scoreboard bench for algorithm_zoom_selector: every expected start pulse is
// queued with its configuration and matched when the DUT raises start.
module tb_algorithm_zoom_selector;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       key_zoom_in_n, key_zoom_out_n, busy;
  logic [1:0] algorithm_select;
  logic [2:0] zoom_level;
  logic       start, no_switch_selected_error, multiple_switches_error, invalid_zoom_error;

  typedef struct packed {
    logic [1:0] alg;
    logic [2:0] zoom;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   nosw_seen = 1'b0;

  algorithm_zoom_selector #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .key_zoom_in_n(key_zoom_in_n), .key_zoom_out_n(key_zoom_out_n), .busy(busy),
    .algorithm_select(algorithm_select), .zoom_level(zoom_level), .start(start),
    .no_switch_selected_error(no_switch_selected_error),
    .multiple_switches_error(multiple_switches_error),
    .invalid_zoom_error(invalid_zoom_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int alg, input int zoom,
                              input int nsw, input int msw, input int inv);
    check_eq({tag, "_alg"},  int'(algorithm_select), alg);
    check_eq({tag, "_zoom"}, int'(zoom_level), zoom);
    check_eq({tag, "_nosw"}, int'(no_switch_selected_error), nsw);
    check_eq({tag, "_multi"}, int'(multiple_switches_error), msw);
    check_eq({tag, "_inv"},  int'(invalid_zoom_error), inv);
  endtask

  task automatic push_exp(input logic [1:0] alg, input logic [2:0] zoom);
    exp_t e;
    e.alg  = alg;
    e.zoom = zoom;
    sb.push_back(e);
  endtask

  task automatic set_sw(input logic [3:0] v);
    sw = v;
    repeat (DB + 8) @(posedge clk);
    #1;
  endtask

  // k[0] = zoom in, k[1] = zoom out
  task automatic press(input logic [1:0] k);
    key_zoom_in_n  = ~k[0];
    key_zoom_out_n = ~k[1];
    repeat (DB + 6) @(posedge clk);
    key_zoom_in_n  = 1'b1;
    key_zoom_out_n = 1'b1;
    repeat (DB + 6) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (no_switch_selected_error === 1'b1) nosw_seen = 1'b1;
    if (start === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_start", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("start_alg", int'(algorithm_select), int'(e.alg));
        check_eq("start_zoom", int'(zoom_level), int'(e.zoom));
      end
    end
  end

  initial begin
    reset          = 1'b0;
    sw             = 4'b0001;
    key_zoom_in_n  = 1'b1;
    key_zoom_out_n = 1'b1;
    busy           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_state("in_reset", 0, 2, 0, 0, 0);
    check_eq("in_reset_start", int'(start), 0);

    // post-reset settle: first commit lands exactly DB+3 edges after release
    push_exp(2'd0, 3'd2);
    @(negedge clk);
    reset = 1'b1;
    repeat (DB + 2) @(posedge clk);
    #1;
    check_eq("settle_early_start", int'(start), 0);
    @(posedge clk);
    #1;
    check_eq("settle_start", int'(start), 1);
    expect_state("settle", 0, 2, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("settle_nosw_never", int'(nosw_seen), 0);
    check_eq("settle_drain", sb.size(), 0);

    // NN zoom-in to the upper limit, then back down
    push_exp(2'd0, 3'd3);
    press(2'b01);
    expect_state("nn_in1", 0, 3, 0, 0, 0);
    push_exp(2'd0, 3'd4);
    press(2'b01);
    expect_state("nn_in2", 0, 4, 0, 0, 0);
    press(2'b01);
    expect_state("nn_in3", 0, 4, 0, 0, 1);
    push_exp(2'd0, 3'd3);
    press(2'b10);
    expect_state("nn_out", 0, 3, 0, 0, 0);
    check_eq("nn_drain", sb.size(), 0);

    // decimation from 1x
    push_exp(2'd2, 3'd2);
    set_sw(4'b0100);
    expect_state("dec_sel", 2, 2, 0, 0, 0);
    press(2'b01);
    expect_state("dec_in", 2, 2, 0, 0, 1);
    push_exp(2'd2, 3'd1);
    press(2'b10);
    expect_state("dec_out1", 2, 1, 0, 0, 0);
    push_exp(2'd2, 3'd0);
    press(2'b10);
    press(2'b10);
    expect_state("dec_out_min", 2, 0, 0, 0, 1);
    check_eq("dec_drain", sb.size(), 0);

    // switch errors
    set_sw(4'b0110);
    expect_state("multi", 2, 0, 0, 1, 0);
    press(2'b01);
    expect_state("multi_press", 2, 0, 0, 1, 0);
    set_sw(4'b0000);
    expect_state("none", 2, 0, 1, 0, 0);
    push_exp(2'd3, 3'd2);
    set_sw(4'b1000);
    expect_state("avg", 3, 2, 0, 0, 0);
    check_eq("swerr_drain", sb.size(), 0);

    // busy handshake: start held off until busy drops
    busy = 1'b1;
    set_sw(4'b0010);
    expect_state("busy_pend", 1, 2, 0, 0, 0);
    push_exp(2'd1, 3'd2);
    busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("busy_drain", sb.size(), 0);
    busy = 1'b1;
    press(2'b01);
    expect_state("busy_press", 1, 2, 0, 0, 0);
    busy = 1'b0;

    // glitches and simultaneous keys
    key_zoom_in_n = 1'b0;
    repeat (2) @(posedge clk);
    key_zoom_in_n = 1'b1;
    repeat (DB + 8) @(posedge clk);
    #1;
    expect_state("key_glitch", 1, 2, 0, 0, 0);
    sw = 4'b0001;
    repeat (2) @(posedge clk);
    sw = 4'b0010;
    repeat (DB + 8) @(posedge clk);
    #1;
    expect_state("sw_glitch", 1, 2, 0, 0, 0);
    press(2'b11);
    expect_state("both_keys", 1, 2, 0, 0, 0);
    check_eq("glitch_drain", sb.size(), 0);

    // reset while a start is pending
    busy = 1'b1;
    set_sw(4'b0100);
    expect_state("pend_dec", 2, 2, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    expect_state("pend_reset", 0, 2, 0, 0, 0);
    check_eq("pend_reset_start", int'(start), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("pend_final_start", int'(start), 0);
    check_eq("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/algorithm_zoom_selector.md
# algorithm_zoom_selector

Front-panel input stage of the image-scaler control path. Synchronizes and debounces the four algorithm switches and the two zoom pushbuttons. Decodes them into `algorithm_select` and a zoom level, and issues a one-cycle `start` to the scaler core. It drives the error flags consumed directly by the HEX scrolling-text display stage, so flag semantics and priority must match that consumer.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles an input must be stable before commit; the bench uses 4.
- `clk`  in  1: system clock, 50 MHz. One clock domain; reset is asynchronous and active-low.
- `reset`  in  1: asynchronous, active-low reset.
- `sw`  in  4: raw algorithm switches, one-hot intent:
  - [0] nearest neighbor
  - [1] pixel replication
  - [2] decimation
  - [3] block averaging
- `key_zoom_in_n`  in  1: raw pushbutton, active-low.
- `key_zoom_out_n`  in  1: raw pushbutton, active-low.
- `busy`  in  1: scaler core processing a frame.
- `algorithm_select`  out  2: encoding 00 NN, 01 replication, 10 decimation, 11 block averaging.
- `zoom_level`  out  3: 0 = 1/4x, 1 = 1/2x, 2 = 1x, 3 = 2x, 4 = 4x; values 5–7 never driven.
- `start`  out  1: one-cycle pulse when a new algorithm/zoom configuration is accepted.
- `no_switch_selected_error`  out  1: no switch on.
- `multiple_switches_error`  out  1: two or more switches on.
- `invalid_zoom_error`  out  1: last zoom request was out of range for the algorithm.

## Operation
- **Synchronization:** every raw input passes through a 2-flop synchronizer, then a debouncer.
  - The switch bus is debounced as one 4-bit word: a commit happens only after the whole word is unchanged for `DEBOUNCE_CYCLES`.
- **Key press:** the committed key level goes 1→0. Release and hold generate nothing.
- **Switch decode** of committed `sw`, by popcount:
  - 0 → `no_switch_selected_error` = 1.
  - ≥2 → `multiple_switches_error` = 1.
  - Exactly 1 → both flags 0 and `algorithm_select` = the index of the set bit.
  - While either switch error is set, `algorithm_select` and `zoom_level` hold their last values and key presses are ignored.
- **Algorithm change:** the committed one-hot value differs from the current `algorithm_select`.
  - `zoom_level` ← 2, `invalid_zoom_error` ← 0.
  - `start` pulses if `busy` = 0; otherwise `start` stays pending and pulses on the first cycle `busy` = 0.
- **Allowed zoom range:**
  - NN and replication: 2..4.
  - Decimation and block averaging: 0..2.
- **Press handling** (no switch error, `busy` = 0):
  - Zoom-in press: if `zoom_level` + 1 is in range, increment, pulse `start`, clear `invalid_zoom_error`; otherwise hold `zoom_level` and set `invalid_zoom_error`.
  - Zoom-out press: symmetric, using decrement.
- **Flag clearing:** `invalid_zoom_error` stays set until the next accepted press, an algorithm change, or a switch error becoming active.
- **Presses while `busy` = 1:** dropped silently; no error, no pending.
- **Simultaneous events:**
  - Both keys pressed in the same cycle → ignored.
  - Algorithm change and a key press in the same cycle → the algorithm change wins and the press is dropped.
  - A switch error appearing clears any pending `start`.
- **Control FSM:**
  - IDLE: wait for an event.
  - PEND: a `start` is owed and `busy` = 1.
  - FIRE: `start` = 1 for one cycle, then return to IDLE.
  - IDLE → FIRE directly when the triggering event occurs with `busy` = 0.

## Timing
- **Reset values:**
  - `algorithm_select` = 00, `zoom_level` = 2, `start` = 0, all error flags 0.
  - The FSM is in IDLE.
  - Synchronizer and debouncer state = inputs released (`sw` = 0000, keys = 1).
- **Post-reset suppression:** switch error flags stay forced 0 until the first switch commit, which occurs `DEBOUNCE_CYCLES` + 3 edges after reset release. This prevents a spurious "select" message.
- **Latency:**
  - A raw change held stable appears on the outputs exactly `DEBOUNCE_CYCLES` + 3 rising edges later (2 synchronizer + debounce + 1 output register).
  - `start` asserts in the same cycle as the updated `zoom_level`/`algorithm_select`.
- All outputs are registered; there are no combinational paths from input to output.
- **Glitch handling:** a raw glitch shorter than `DEBOUNCE_CYCLES` never commits. The debounce counter restarts on every change.
- **Reset mid-operation:** takes effect immediately (asynchronous), drops any pending `start`, and returns to the reset values. Release is synchronous to `clk`.

## Structure
- **Shared header `scaler_defs`:**
  - Algorithm codes (NN = 0, REPL = 1, DEC = 2, AVG = 3).
  - Zoom level constants `ZOOM_QUARTER` … `ZOOM_4X`.
  - Per-algorithm min/max zoom constants. The scaler core and display stage also use these.
- **Sub-module `input_debouncer`** (parameters `WIDTH`, `DEBOUNCE_CYCLES`): contains the synchronizer and the debounce counter.
  - Instantiated once for the 4-bit `sw` bus.
  - Instantiated once for the 2-bit key bus.

## Test plan
- **Post-reset settle:** reset, then `sw` = 0001, keys high, `DEBOUNCE_CYCLES` = 4 → after 7 cycles `algorithm_select` = 00, `zoom_level` = 2, all flags 0, and `start` pulses once. `no_switch_selected_error` is never 1.
- **Zoom-in to the upper limit:** NN selected, 3 zoom-in presses → `zoom_level` 3, 4, 4. The third press sets `invalid_zoom_error`; one zoom-out press gives `zoom_level` = 3 and clears the flag.
- **Decimation from 1x:** `sw` = 0100 from `zoom_level` 2.
  - Zoom-in press → `invalid_zoom_error` = 1, `zoom_level` stays 2.
  - Zoom-out press → `zoom_level` = 1 with one `start` pulse.
- **Switch errors:** `sw` = 0110 → `multiple_switches_error` = 1, presses ignored, `algorithm_select` held. `sw` = 0000 → `no_switch_selected_error` = 1. `sw` = 1000 → `algorithm_select` = 11, `zoom_level` = 2, `start` pulses.
- **Busy handshake:** with `busy` = 1, an algorithm change → no `start` while busy; `start` pulses on the first cycle `busy` = 0. A press during `busy` produces no change.
- **Glitches and simultaneous events:**
  - A 2-cycle low pulse on `key_zoom_in_n` → no change.
  - Both keys pressed together → no change.
  - Reset asserted while in PEND → `start` never fires and the outputs return to reset values.
